// File: rtl/mac_acc_readout.sv
// Readout stage for the MAC accumulator: a 2-entry snapshot FIFO feeding a
// byte serializer that emits {ovf,drop,seq} followed by the accumulator LSB first.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no frame in flight; pops the FIFO head as soon as one exists
// SEND  | frame register drives header (idx=0) then data bytes 1..NBYTES
module mac_acc_readout #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cap_stb,
    input  logic [ACC_W-1:0] acc_in,
    input  logic             acc_ovf_in,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int NBYTES = ACC_W / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int ENT_W  = ACC_W + 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [ENT_W-1:0] r_frame;
    logic [ENT_W-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [5:0]       r_seq;
    logic             r_drop;

    logic             w_send;
    logic             w_empty;
    logic             w_full;
    logic             w_xfer;
    logic             w_idx_last;
    logic             w_pop;
    logic             w_cap;
    logic [ENT_W-1:0] w_entry;
    logic [7:0]       w_sel;

    assign w_send     = (r_state == ST_SEND);
    assign w_empty    = (r_count == 2'd0);
    assign w_full     = (r_count == 2'd2);
    assign w_xfer     = ena & w_send & out_ready;
    assign w_idx_last = (r_idx == IDX_LAST);

    // A pop frees a slot in the same cycle, so a capture into a full FIFO still lands.
    assign w_pop   = ena & ~w_empty & (~w_send | (w_xfer & w_idx_last));
    assign w_cap   = ena & cap_stb & (~w_full | w_pop);
    assign w_entry = {acc_ovf_in, r_drop, r_seq, acc_in};

    always_comb begin
        w_sel = r_frame[ACC_W +: 8];
        for (int k = 1; k <= NBYTES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel = r_frame[(k-1)*8 +: 8];
            end
        end
    end

    assign out_valid = ena & w_send;
    assign out_last  = out_valid & w_idx_last;
    assign out_byte  = w_send ? w_sel : 8'h00;
    assign busy      = ~w_empty | w_send;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_cap) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_cap, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq  <= 6'd0;
            r_drop <= 1'b0;
        end else if (w_cap) begin
            r_seq  <= r_seq + 6'd1;
            r_drop <= 1'b0;
        end else if (ena & cap_stb) begin
            r_drop <= 1'b1;
        end
    end

    // w_pop and w_xfer already carry ena, so the FSM freezes with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_frame <= r_mem[r_rd_ptr];
                        r_idx   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (w_idx_last) begin
                            if (w_pop) begin
                                r_frame <= r_mem[r_rd_ptr];
                                r_idx   <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_acc_readout.sv
// Scoreboard bench for mac_acc_readout: a frame-level model pushes expected
// bytes on accepted captures; a monitor pops and compares on every valid byte.
module tb_mac_acc_readout;

    localparam int ACC_W = 24;
    localparam int NB    = ACC_W / 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             cap_stb;
    logic [ACC_W-1:0] acc_in;
    logic             acc_ovf_in;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    always #5 clk = ~clk;

    mac_acc_readout #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cap_stb   (cap_stb),
        .acc_in    (acc_in),
        .acc_ovf_in(acc_ovf_in),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    // {last, byte} in transmission order
    logic [8:0] exp_q[$];

    // Model state: snapshots waiting, frame in flight, bytes left in it
    int       m_fifo_n;
    bit       m_inflight;
    int       m_rem;
    logic [5:0] m_seq;
    bit       m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit t_xfer;
        bit t_pop;
        bit t_acc;
        logic [7:0] t_hdr;
        if (!rst_n) begin
            m_fifo_n   = 0;
            m_inflight = 0;
            m_rem      = 0;
            m_seq      = 6'd0;
            m_drop     = 0;
            exp_q.delete();
        end else if (ena) begin
            t_xfer = m_inflight && out_ready;
            t_pop  = (m_fifo_n > 0) && (!m_inflight || (t_xfer && m_rem == 1));
            t_acc  = cap_stb && (m_fifo_n < 2 || t_pop);
            if (t_xfer) begin
                m_rem--;
                if (m_rem == 0) m_inflight = 0;
            end
            if (t_pop) begin
                m_fifo_n--;
                m_inflight = 1;
                m_rem      = NB + 1;
            end
            if (t_acc) begin
                t_hdr = {acc_ovf_in, m_drop, m_seq};
                exp_q.push_back({1'b0, t_hdr});
                for (int k = 0; k < NB; k++) begin
                    exp_q.push_back({(k == NB - 1) ? 1'b1 : 1'b0, acc_in[8*k +: 8]});
                end
                m_fifo_n++;
                m_seq  = m_seq + 6'd1;
                m_drop = 0;
            end else if (cap_stb) begin
                m_drop = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_inflight && ena));
            chk("busy", 32'(busy), 32'((m_fifo_n != 0) || m_inflight));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", out_byte, $time);
                end else begin
                    chk("out_byte", 32'(out_byte), 32'(exp_q[0][7:0]));
                    chk("out_last", 32'(out_last), 32'(exp_q[0][8]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [ACC_W-1:0] a, input logic o);
        cap_stb    = 1'b1;
        acc_in     = a;
        acc_ovf_in = o;
        cyc();
        cap_stb    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_inflight || m_fifo_n != 0 || exp_q.size() != 0 || busy) && n < budget) begin
            cyc();
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_byte"},  32'(out_byte),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        int start;
        int n;
        rst_n      = 1'b0;
        ena        = 1'b1;
        cap_stb    = 1'b0;
        acc_in     = '0;
        acc_ovf_in = 1'b0;
        out_ready  = 1'b1;
        repeat (3) cyc();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        cyc();
        chk_reset_outputs("post_rst");

        // single capture
        strobe(24'h123456, 1'b0);
        wait_idle(20);

        // three back-to-back captures, ovf on the second
        strobe(24'h000001, 1'b0);
        strobe(24'h000002, 1'b1);
        strobe(24'h000003, 1'b0);
        wait_idle(40);

        // overflow: fourth capture dropped, next header carries drop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(ACC_W'($urandom), 1'b0);
        repeat (3) cyc();
        out_ready = 1'b1;
        wait_idle(40);
        strobe(24'h0BEEF0, 1'b0);
        wait_idle(20);

        // random backpressure
        strobe(24'hA5B6C7, 1'b0);
        n = 0;
        while ((m_inflight || m_fifo_n != 0) && n < 80) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        out_ready = 1'b1;
        wait_idle(20);

        // enable gating mid-frame with ignored strobes
        strobe(24'h3C4D5E, 1'b1);
        cyc();
        cyc();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cap_stb = (i % 2 == 0) ? 1'b1 : 1'b0;
            acc_in  = ACC_W'($urandom);
            cyc();
        end
        cap_stb = 1'b0;
        ena     = 1'b1;
        wait_idle(20);

        // reset mid-frame after the second byte
        start = n_xfer;
        strobe(24'h778899, 1'b0);
        n = 0;
        while (n_xfer < start + 2 && n < 20) begin
            cyc();
            n++;
        end
        n_vec++;
        if (n >= 20) begin
            n_err++;
            $display("FAIL midframe_wait: got %0d bytes expected 2", n_xfer - start);
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        strobe(24'h010203, 1'b0);
        wait_idle(20);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ena        = ($urandom_range(0, 9) != 0);
            cap_stb    = ($urandom_range(0, 2) == 0);
            acc_in     = ACC_W'($urandom);
            acc_ovf_in = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            cyc();
        end
        cap_stb   = 1'b0;
        ena       = 1'b1;
        out_ready = 1'b1;
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_acc_readout.md
# mac_acc_readout

Downstream readout stage for the 8-bit MAC core. It snapshots the MAC accumulator on a capture strobe and queues up to two snapshots. Each snapshot is emitted as a 4-byte frame over an 8-bit valid/ready byte stream that feeds the chip's dedicated output pins. The frame is one header byte followed by the accumulator bytes, LSB first.

## Interface
Parameters:
- ACC_W, 24, accumulator width in bits; must be a multiple of 8.
- NBYTES, ACC_W/8, number of data bytes per frame (derived, not overridden).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  design enable; when low, all state is frozen.
- cap_stb  input  1  one-cycle capture request for acc_in / acc_ovf_in.
- acc_in  input  ACC_W  MAC accumulator value, two's complement.
- acc_ovf_in  input  1  MAC overflow flag accompanying acc_in.
- out_byte  output  8  current frame byte.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts the byte; transfer occurs when valid and ready are both high at a clock edge.
- out_last  output  1  high with the final data byte of a frame.
- busy  output  1  high if the FIFO holds any entry or a frame is in flight.

## Operation
- Snapshot FIFO: 2 entries, each {ovf, drop, seq[5:0], acc[ACC_W-1:0]}.
- Capture (ena=1, cap_stb=1):
  - The capture is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - On accept, the entry is written with ovf=acc_ovf_in, drop=drop_pend, seq=seq_cnt.
  - On accept, seq_cnt increments modulo 64 and drop_pend clears.
  - Otherwise the capture is discarded and drop_pend is set.
- Serializer FSM:
  - IDLE: out_valid=0. If the FIFO is non-empty, pop the head into the frame register, set idx=0, and go to SEND.
  - SEND: out_valid=1. idx=0 drives the header {ovf, drop, seq[5:0]}. idx=k (1..NBYTES) drives acc[8k-1:8k-8]. out_last=1 when idx=NBYTES.
  - On each transfer, idx increments.
  - On the transfer with idx=NBYTES: if the FIFO is non-empty, pop and reload the frame register with idx=0 and stay in SEND (back-to-back frames, no bubble). Otherwise go to IDLE.
- out_byte and out_last hold stable while out_valid=1 and out_ready=0.
- ena=0: cap_stb is ignored, out_valid is forced to 0, and no state changes (FSM, idx, FIFO, counters all hold). Behaviour resumes unchanged when ena returns to 1.
- busy = (FIFO count != 0) | (state==SEND).

## Timing
- Reset (async assert, sync release):
  - out_valid=0, out_last=0, out_byte=0, busy=0.
  - FSM=IDLE, FIFO empty, seq_cnt=0, drop_pend=0.
- Reset asserted mid-frame aborts the frame immediately. The partial frame is never resumed.
- Latency: a cap_stb sampled at edge E0 with the FSM idle and FIFO empty is written at E0 and loaded at E1. out_valid=1 follows E1, carrying the header.
- Throughput: 1 byte per cycle with out_ready held high. A frame occupies NBYTES+1 cycles.
- Simultaneous capture and pop with the FIFO full: the capture is accepted and no drop is recorded.
- Up to 3 snapshots can be outstanding: one in the frame register and two in the FIFO.
- seq wraps from 63 to 0.

## Test plan
- Single capture: acc_in=0x123456, ovf=0, out_ready=1 -> out_valid rises 2 edges after the strobe. Bytes are 0x00, 0x56, 0x34, 0x12, with out_last only on 0x12. Then IDLE and busy=0.
- Back-to-back: 3 strobes on consecutive cycles (0x000001, 0x000002, 0x000003, ovf=1 on the second) -> 12 consecutive bytes with no gaps. Headers are 0x00, 0x81, 0x02.
- Overflow/drop: hold out_ready=0 and issue 4 strobes -> the 4th is dropped. After releasing out_ready, 3 frames arrive with seq 0, 1, 2. The next accepted capture has header 0x43 (drop=1, seq=3).
- Backpressure: toggle out_ready pseudo-randomly during a frame of 0xA5B6C7 -> byte order is unchanged, out_byte is stable while stalled, and no byte is duplicated or lost.
- ena gating: deassert ena for 5 cycles mid-frame while pulsing cap_stb -> out_valid=0 and the strobes are ignored. The frame resumes at the same idx when ena returns.
- Reset mid-frame: assert rst_n=0 after the 2nd byte -> outputs go to reset values asynchronously. A subsequent capture starts at seq 0.
